uart_word_sender: RTL and testbench

//   Downstream of uart_test's ToPC word: serializes a WORD_BITS-wide word into bytes
//   and drives the byte-level uart transmitter (uart_send/uart_send_done) one byte at a time.

---
 rtl/uart_word_sender.sv | 143 ++++++++++++++
 tb/tb_uart_word_sender.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_word_sender.sv
// uart_word_sender: splits a WORD_BITS word into bytes and hands them one at a time to a byte UART.
// Define UART_FRAME_CHECKSUM_EN to frame each word with an 0xA5 header and a trailing XOR checksum.
module uart_word_sender #(
   parameter int WORD_BITS      = 32,
   parameter bit MSB_FIRST      = 1'b1,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 send,
   input  logic [WORD_BITS-1:0] data,
   output logic                 busy,
   output logic                 send_done,
   output logic                 error,
   output logic                 uart_send,
   output logic [7:0]           uart_send_data,
   input  logic                 uart_send_done,
   output logic [3:0]           sta
);
   localparam int CW = $clog2(WORD_BITS / 8 + 1);
   localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   typedef enum logic [3:0] {
      IDLE = 4'd0, LOAD = 4'd1, HDR = 4'd2, REQ = 4'd3, ACK = 4'd4,
      REL = 4'd5, NEXT = 4'd6, CHK = 4'd7, DONE = 4'd8, ERR = 4'd9
   } state_t;
   state_t               state_q, state_d;
   logic [WORD_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0]        count_q, count_d;
   logic [1:0]           sync_q;
   logic                 done_last_q, send_q;
   logic                 done_s, rise, start, tmo_hit;
   logic [7:0]           cur_byte, req_byte;
`ifdef UART_FRAME_CHECKSUM_EN
   localparam logic [1:0] K_HDR = 2'd0, K_DAT = 2'd1, K_CHK = 2'd2;
   logic [7:0] chk_q, chk_d;
   logic [1:0] kind_q, kind_d;
`endif
   assign done_s   = sync_q[1];
   assign rise     = done_s & ~done_last_q;
   assign start    = send & ~send_q;
   assign cur_byte = MSB_FIRST ? shift_q[WORD_BITS-1 -: 8] : shift_q[7:0];
`ifdef UART_FRAME_CHECKSUM_EN
   assign req_byte = kind_q == K_HDR ? 8'hA5 : kind_q == K_CHK ? chk_q : cur_byte;
`else
   assign req_byte = cur_byte;
`endif
   assign busy           = state_q != IDLE;
   assign send_done      = state_q == DONE;
   assign error          = state_q == ERR;
   assign uart_send      = state_q inside {HDR, REQ, CHK, ACK};
   assign uart_send_data = uart_send ? req_byte : 8'h00;
   assign sta            = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         count_q     <= '0;
         sync_q      <= '0;
         done_last_q <= 1'b0;
         send_q      <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
         chk_q       <= '0;
         kind_q      <= K_DAT;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         count_q     <= count_d;
         sync_q      <= {sync_q[0], uart_send_done};
         done_last_q <= done_s;
         send_q      <= send;
`ifdef UART_FRAME_CHECKSUM_EN
         chk_q       <= chk_d;
         kind_q      <= kind_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      count_d = count_q;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_d   = chk_q;
      kind_d  = kind_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            shift_d = data;
         end
         LOAD: begin
            count_d = CW'(WORD_BITS / 8);
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = HDR;
            kind_d  = K_HDR;
            chk_d   = '0;
`else
            state_d = REQ;
`endif
         end
         HDR, REQ, CHK: state_d = ACK;
         // an acknowledge or release seen in the same cycle as the timeout still counts
         ACK: state_d = rise ? REL : tmo_hit ? ERR : ACK;
         REL: state_d = !done_s ? NEXT : tmo_hit ? ERR : REL;
         NEXT: begin
`ifdef UART_FRAME_CHECKSUM_EN
            if (kind_q == K_HDR) begin
               state_d = REQ;
               kind_d  = K_DAT;
            end else if (kind_q == K_CHK) begin
               state_d = DONE;
            end else begin
               shift_d = MSB_FIRST ? shift_q << 8 : shift_q >> 8;
               count_d = count_q - 1'b1;
               chk_d   = chk_q ^ cur_byte;
               state_d = count_d != '0 ? REQ : CHK;
               kind_d  = count_d != '0 ? K_DAT : K_CHK;
            end
`else
            shift_d = MSB_FIRST ? shift_q << 8 : shift_q >> 8;
            count_d = count_q - 1'b1;
            state_d = count_d != '0 ? REQ : DONE;
`endif
         end
         DONE, ERR: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   if (TIMEOUT_CYCLES > 0) begin : g_tmo
      logic [TW-1:0] tmo_q, tmo_d;
      assign tmo_d   = (state_q inside {ACK, REL}) && state_d == state_q ? tmo_q + 1'b1 : '0;
      assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES);
      always_ff @(posedge clk or posedge rst) begin
         if (rst) tmo_q <= '0;
         else     tmo_q <= tmo_d;
      end
   end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
   end
endmodule

// File: tb/tb_uart_word_sender.sv
// tb_uart_word_sender: directed checks of two sender instances (MSB-first with 50-cycle timeout,
// LSB-first without) against a byte-UART model on a separate clock.
module tb_uart_word_sender;
   logic        clk = 1'b0, uclk = 1'b0, rst = 1'b1;
   logic        send[2], busy[2], sdone[2], err[2], us[2], ud[2], ack_en[2];
   logic [31:0] data[2];
   logic [7:0]  usd[2];
   logic [3:0]  sta[2];
   int          ndone[2], nerr[2];
   logic [7:0]  got0[$], got1[$], exp_m[$], exp_l[$], exp_01[$];
   int          n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;
   always #7 uclk = ~uclk;

   for (genvar k = 0; k < 2; k++) begin : g
      int cnt = 0;
      uart_word_sender #(.WORD_BITS(32), .MSB_FIRST(k == 0), .TIMEOUT_CYCLES(k == 0 ? 50 : 0)) dut (
         .clk(clk), .rst(rst), .send(send[k]), .data(data[k]), .busy(busy[k]),
         .send_done(sdone[k]), .error(err[k]), .uart_send(us[k]), .uart_send_data(usd[k]),
         .uart_send_done(ud[k]), .sta(sta[k]));
      always @(posedge uclk) begin
         if (!us[k] || !ack_en[k]) begin
            ud[k] <= 1'b0;
            cnt   <= 0;
         end else if (!ud[k]) begin
            if (cnt == 9) begin
               ud[k] <= 1'b1;
               if (k == 0) got0.push_back(usd[k]);
               else        got1.push_back(usd[k]);
            end else cnt <= cnt + 1;
         end
      end
      always @(posedge clk) begin
         if (sdone[k]) ndone[k] = ndone[k] + 1;
         if (err[k])   nerr[k]  = nerr[k] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
      chk({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), i < got.size() ? {24'h0, got[i]} : 32'hxxxxxxxx, {24'h0, exp[i]});
   endtask

   task automatic pulse(input int w, input logic [31:0] d);
      data[w] = d;
      @(negedge clk) send[w] = 1'b1;
      @(negedge clk) send[w] = 1'b0;
   endtask

   task automatic wait_idle(input int w, input string tag);
      int n = 0;
      while (busy[w] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, busy[w], 1'b0);
   endtask

   task automatic run(input int w, input logic [31:0] d, input string tag, input logic [7:0] exp[$]);
      int d0 = ndone[w];
      got0.delete();
      got1.delete();
      pulse(w, d);
      chk({tag, "_busy"}, busy[w], 1'b1);
      wait_idle(w, tag);
      chk({tag, "_ndone"}, ndone[w] - d0, 1);
      chk_bytes(tag, w == 0 ? got0 : got1, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, d0;
`ifdef UART_FRAME_CHECKSUM_EN
      exp_m  = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
      exp_l  = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      exp_01 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
`else
      exp_m  = '{8'h12, 8'h34, 8'h56, 8'h78};
      exp_l  = '{8'h78, 8'h56, 8'h34, 8'h12};
      exp_01 = '{8'h01, 8'h02, 8'h03, 8'h04};
`endif
      for (int i = 0; i < 2; i++) begin
         send[i] = 1'b0; data[i] = '0; ack_en[i] = 1'b1; ndone[i] = 0; nerr[i] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", busy[0], 1'b0);
      chk("rst_uart_send", us[0], 1'b0);
      chk("rst_uart_data", usd[0], 8'h00);
      chk("rst_sta", sta[0], 4'd0);
      chk("rst_done_err", {sdone[0], err[0], sdone[1], err[1]}, 4'b0000);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run(0, 32'h12345678, "msb", exp_m);
      run(1, 32'h12345678, "lsb", exp_l);

      d0 = ndone[0];
      pulse(0, 32'hCAFEF00D);
      n = 0;
      while (sta[0] != 4'd4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("mid_ack_reached", sta[0], 4'd4);
      chk("mid_ack_uart_send", us[0], 1'b1);
      rst = 1'b1;
      #1;
      chk("arst_uart_send", us[0], 1'b0);
      chk("arst_busy", busy[0], 1'b0);
      chk("arst_sta", sta[0], 4'd0);
      @(negedge clk) rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("arst_no_done", ndone[0] - d0, 0);
      chk("arst_still_idle", busy[0], 1'b0);

      ack_en[0] = 1'b0;
      got0.delete();
      pulse(0, 32'h12345678);
      n = 0;
      while (sta[0] != 4'd4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (sta[0] != 4'd9 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", n, 51);
      chk("tmo_error_pulse", err[0], 1'b1);
      chk("tmo_uart_send", us[0], 1'b0);
      @(negedge clk);
      chk("tmo_error_low", err[0], 1'b0);
      chk("tmo_sta_idle", sta[0], 4'd0);
      chk("tmo_busy", busy[0], 1'b0);
      chk("tmo_nerr", nerr[0], 1);
      chk("tmo_no_bytes", got0.size(), 0);
      ack_en[0] = 1'b1;
      repeat (5) @(negedge clk);
      run(0, 32'h01020304, "after_tmo", exp_01);
      chk("after_tmo_nerr", nerr[0], 1);

      d0 = ndone[1];
      got1.delete();
      data[1] = 32'h12345678;
      @(negedge clk) send[1] = 1'b1;
      repeat (20) @(negedge clk);
      chk("held_busy", busy[1], 1'b1);
      send[1] = 1'b0;
      @(negedge clk) send[1] = 1'b1;
      wait_idle(1, "held");
      repeat (40) @(negedge clk);
      chk("held_no_restart", busy[1], 1'b0);
      chk("held_ndone", ndone[1] - d0, 1);
      chk_bytes("held", got1, exp_l);
      send[1] = 1'b0;
      got1.delete();
      @(negedge clk) send[1] = 1'b1;
      @(negedge clk);
      chk("reedge_busy", busy[1], 1'b1);
      wait_idle(1, "reedge");
      repeat (40) @(negedge clk);
      chk("reedge_ndone", ndone[1] - d0, 2);
      chk_bytes("reedge", got1, exp_l);
      send[1] = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
